framebuffer_write_arbiter: RTL and testbench
============================================

# framebuffer_write_arbiter

Shares the single write port of the 160×120, 8-bit-per-pixel framebuffer between two requesters: CPU pixel writes and a hardware clear engine that fills the whole frame with one colour. It sits between the processor bus and the framebuffer's `write`/`x_data`/`y_data`/`color` port. The HDMI read side (`x`, `y`, `pixelData`) is untouched. Arbitration is round-robin when both requesters compete, so neither starves.

## Interface
- `WIDTH`, default 160: pixels per line; x index range 0..WIDTH-1.
- `HEIGHT`, default 120: lines per frame; y index range 0..HEIGHT-1.
- `COORD_W`, default 8: width of the x and y coordinates.
- `COLOR_W`, default 8: pixel colour width.

Ports:
- `clk` in 1: pixel clock; the same clock as the framebuffer.
- `rst` in 1: asynchronous, active-low reset.
- `cpu_valid` in 1: CPU write request.
- `cpu_ready` out 1: CPU write accepted this cycle when high together with `cpu_valid`.
- `cpu_x` in COORD_W: CPU pixel x coordinate.
- `cpu_y` in COORD_W: CPU pixel y coordinate.
- `cpu_color` in COLOR_W: CPU pixel colour.
- `clr_start` in 1: one-cycle pulse that starts a full-frame clear.
- `clr_color` in COLOR_W: fill colour, sampled on `clr_start`.
- `clr_busy` out 1: a clear is in progress.
- `fb_write` out 1: framebuffer write strobe.
- `fb_x_data` out COORD_W: framebuffer write x coordinate.
- `fb_y_data` out COORD_W: framebuffer write y coordinate.
- `fb_color` out COLOR_W: framebuffer write colour.
- `err_oob` out 1: out-of-range CPU write dropped (see Configuration).

## Operation
- Clear engine states:
  - IDLE → CLEAR on `clr_start`, which latches `clr_color` and resets cx=0, cy=0.
  - CLEAR → IDLE after the write at (WIDTH-1, HEIGHT-1) is granted.
  - `clr_start` while in CLEAR is ignored; the fill colour does not change.
- Clear scan order:
  - cx advances on every clear grant.
  - At cx=WIDTH-1, cx wraps to 0 and cy increments.
  - No coordinate ever reaches WIDTH or HEIGHT.
- Request lines: clear requests whenever in CLEAR; the CPU requests when `cpu_valid` is high.
- Arbitration:
  - A lone requester is always granted.
  - When both request, the requester not granted last time wins.
  - The `last_grant` bit updates only on a contended grant; its reset value is CPU, so clear wins the first conflict.
- `cpu_ready` is combinational: high unless clear is requesting and wins this cycle. `cpu_ready` may be high while `cpu_valid` is low.
- Throughput and latency of a clear:
  - 19200 cycles (WIDTH·HEIGHT) with no CPU traffic.
  - At most 38400 cycles with continuous CPU traffic.
  - A waiting CPU write stalls at most 1 cycle.
- Coordinate arithmetic is unsigned COORD_W; no CPU-supplied coordinate is modified.

## Timing
- All fb_* outputs are registered: a grant in cycle N gives `fb_write`=1 with that requester's data in cycle N+1.
- `fb_write` is 0 in any cycle following a cycle with no grant. fb_x_data, fb_y_data and fb_color then hold their previous values.
- `clr_busy` rises the cycle after `clr_start`. It falls the cycle after the final clear grant, which is the same cycle the last pixel's `fb_write` appears.
- Reset values: `cpu_ready`=0 while `rst` is low. All other outputs are 0, state is IDLE, cx=cy=0, `last_grant`=CPU.
- Reset asserted mid-clear aborts it immediately. The partially cleared frame stays in the framebuffer; there is no resume.
- `clr_start` and `cpu_valid` in the same IDLE cycle: the CPU write is granted that cycle. Clear requests from the next cycle.

## Configuration
- `FB_BOUNDS_CHECK_EN` defined:
  - A CPU write with cpu_x ≥ WIDTH or cpu_y ≥ HEIGHT is still accepted, so `cpu_ready` behaves as normal.
  - No `fb_write` is issued for it.
  - `err_oob` pulses 1 in cycle N+1.
  - The dropped write does not count as a grant for `last_grant`.
- `FB_BOUNDS_CHECK_EN` undefined: out-of-range writes pass through unchanged and `err_oob` is tied to 0.

## Structure
- Package `fb_pkg` holds:
  - FB_WIDTH=160, FB_HEIGHT=120, FB_COORD_W=8, FB_COLOR_W=8.
  - Enum `fb_grant_t` with values NONE, CPU, CLEAR.
  - Enum `fb_clr_state_t` with values IDLE, CLEAR.
- Sub-module `fb_clear_engine` contains the state machine, the cx/cy scan counters and the latched fill colour. It exposes `req`, `grant`, `x`, `y`, `color` and `busy`.
- The top level holds the arbiter, the output registers and the bounds check.

## Test plan
- Reset release, then `cpu_valid` with (5,7,8'hE3) → `cpu_ready`=1 the same cycle; `fb_write`=1 with (5,7,8'hE3) one cycle later.
- `clr_start` with `clr_color`=8'h1C, no CPU traffic:
  - Exactly 19200 `fb_write` pulses, scanning (0,0),(1,0)…(159,0),(0,1)…(159,119), all with colour 8'h1C.
  - `clr_busy` is high for 19200 cycles.
- Clear running with `cpu_valid` held high:
  - Grants strictly alternate, clear first.
  - `cpu_ready` toggles every cycle.
  - The clear completes in 38400 cycles.
- `clr_start` pulsed again mid-clear with a new colour → ignored; every remaining pixel keeps the original colour.
- `rst` low at pixel (40,60) of a clear → next cycle `clr_busy`=0 and `fb_write`=0. A new `clr_start` restarts the scan at (0,0).
- With `FB_BOUNDS_CHECK_EN` defined, CPU write (160,3) → accepted, no `fb_write`, `err_oob`=1 for one cycle. Without the macro, the write passes through with `fb_x_data`=160.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants and enums for the framebuffer write arbiter and its clear engine.
package fb_pkg;
    localparam int FB_WIDTH   = 160;
    localparam int FB_HEIGHT  = 120;
    localparam int FB_COORD_W = 8;
    localparam int FB_COLOR_W = 8;

    // Literals carry a prefix because both enums would otherwise define CLEAR.
    typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_CLEAR} fb_grant_t;
    typedef enum logic       {ST_IDLE, ST_CLEAR}            fb_clr_state_t;
endpackage

// File: rtl/fb_clear_engine.sv
// Full-frame clear engine: raster-scans every pixel once with a colour latched at start.
module fb_clear_engine
    import fb_pkg::*;
#(
    parameter int WIDTH   = FB_WIDTH,
    parameter int HEIGHT  = FB_HEIGHT,
    parameter int COORD_W = FB_COORD_W,
    parameter int COLOR_W = FB_COLOR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COLOR_W-1:0] start_color,
    input  logic               grant,
    output logic               req,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COLOR_W-1:0] color,
    output logic               busy
);
    fb_clr_state_t      state_q, state_d;
    logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               x_last, y_last;

    assign x_last = (cx_q == COORD_W'(WIDTH - 1));
    assign y_last = (cy_q == COORD_W'(HEIGHT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            color_q <= color_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        color_d = color_q;
        case (state_q)
            ST_IDLE: begin
                // start is only honoured here, so a restart mid-clear cannot disturb the colour
                if (start) begin
                    state_d = ST_CLEAR;
                    cx_d    = '0;
                    cy_d    = '0;
                    color_d = start_color;
                end
            end
            ST_CLEAR: begin
                if (grant) begin
                    if (x_last) begin
                        cx_d = '0;
                        cy_d = y_last ? '0 : cy_q + 1'b1;
                        if (y_last) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req   = (state_q == ST_CLEAR);
        busy  = (state_q == ST_CLEAR);
        x     = cx_q;
        y     = cy_q;
        color = color_q;
    end
endmodule

// File: rtl/framebuffer_write_arbiter.sv
// Round-robin arbiter sharing the framebuffer write port between CPU writes and the clear engine.
// Optional FB_BOUNDS_CHECK_EN drops out-of-range CPU writes and pulses err_oob instead.
module framebuffer_write_arbiter
    import fb_pkg::*;
#(
    parameter int WIDTH   = FB_WIDTH,
    parameter int HEIGHT  = FB_HEIGHT,
    parameter int COORD_W = FB_COORD_W,
    parameter int COLOR_W = FB_COLOR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_valid,
    output logic               cpu_ready,
    input  logic [COORD_W-1:0] cpu_x,
    input  logic [COORD_W-1:0] cpu_y,
    input  logic [COLOR_W-1:0] cpu_color,
    input  logic               clr_start,
    input  logic [COLOR_W-1:0] clr_color,
    output logic               clr_busy,
    output logic               fb_write,
    output logic [COORD_W-1:0] fb_x_data,
    output logic [COORD_W-1:0] fb_y_data,
    output logic [COLOR_W-1:0] fb_color,
    output logic               err_oob
);
    logic               clr_req, clr_grant;
    logic [COORD_W-1:0] clr_x, clr_y;
    logic [COLOR_W-1:0] clr_pix;
    logic               cpu_oob, contended, drop;
    fb_grant_t          gnt;
    fb_grant_t          last_grant_q, last_grant_d;
    logic               fb_write_q, fb_write_d, err_oob_q, err_oob_d;
    logic [COORD_W-1:0] fb_x_q, fb_x_d, fb_y_q, fb_y_d;
    logic [COLOR_W-1:0] fb_color_q, fb_color_d;

    fb_clear_engine #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .COORD_W(COORD_W),
        .COLOR_W(COLOR_W)
    ) u_clear (
        .clk        (clk),
        .rst        (rst),
        .start      (clr_start),
        .start_color(clr_color),
        .grant      (clr_grant),
        .req        (clr_req),
        .x          (clr_x),
        .y          (clr_y),
        .color      (clr_pix),
        .busy       (clr_busy)
    );

`ifdef FB_BOUNDS_CHECK_EN
    assign cpu_oob = (int'(cpu_x) >= WIDTH) || (int'(cpu_y) >= HEIGHT);
`else
    assign cpu_oob = 1'b0;
`endif

    always_comb begin
        contended = clr_req && cpu_valid;
        gnt       = GNT_NONE;
        if (contended) begin
            gnt = (last_grant_q == GNT_CPU) ? GNT_CLEAR : GNT_CPU;
        end else if (clr_req) begin
            gnt = GNT_CLEAR;
        end else if (cpu_valid) begin
            gnt = GNT_CPU;
        end
        clr_grant = (gnt == GNT_CLEAR);
        cpu_ready = rst && (gnt != GNT_CLEAR);
        // A dropped out-of-range write is accepted but is not a grant for fairness purposes.
        drop      = (gnt == GNT_CPU) && cpu_oob;

        last_grant_d = last_grant_q;
        if (contended && !drop) begin
            last_grant_d = gnt;
        end

        fb_write_d = (gnt != GNT_NONE) && !drop;
        err_oob_d  = drop;
        fb_x_d     = fb_x_q;
        fb_y_d     = fb_y_q;
        fb_color_d = fb_color_q;
        if (fb_write_d) begin
            fb_x_d     = clr_grant ? clr_x   : cpu_x;
            fb_y_d     = clr_grant ? clr_y   : cpu_y;
            fb_color_d = clr_grant ? clr_pix : cpu_color;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= GNT_CPU;
            fb_write_q   <= 1'b0;
            err_oob_q    <= 1'b0;
            fb_x_q       <= '0;
            fb_y_q       <= '0;
            fb_color_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            fb_write_q   <= fb_write_d;
            err_oob_q    <= err_oob_d;
            fb_x_q       <= fb_x_d;
            fb_y_q       <= fb_y_d;
            fb_color_q   <= fb_color_d;
        end
    end

    assign fb_write  = fb_write_q;
    assign fb_x_data = fb_x_q;
    assign fb_y_data = fb_y_q;
    assign fb_color  = fb_color_q;
    assign err_oob   = err_oob_q;
endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// Scoreboard bench for framebuffer_write_arbiter: stimulus queues expected writes, a monitor pops them.
module tb_framebuffer_write_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cpu_valid = 1'b0;
    logic       cpu_ready;
    logic [7:0] cpu_x = '0, cpu_y = '0, cpu_color = '0;
    logic       clr_start = 1'b0;
    logic [7:0] clr_color = '0;
    logic       clr_busy, fb_write, err_oob;
    logic [7:0] fb_x_data, fb_y_data, fb_color;

    int errors = 0;
    int checks = 0;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    framebuffer_write_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_valid(cpu_valid),
        .cpu_ready(cpu_ready),
        .cpu_x    (cpu_x),
        .cpu_y    (cpu_y),
        .cpu_color(cpu_color),
        .clr_start(clr_start),
        .clr_color(clr_color),
        .clr_busy (clr_busy),
        .fb_write (fb_write),
        .fb_x_data(fb_x_data),
        .fb_y_data(fb_y_data),
        .fb_color (fb_color),
        .err_oob  (err_oob)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic push_pix(input int x, input int y, input logic [7:0] c);
        exp_q.push_back({x[7:0], y[7:0], c});
    endtask

    task automatic push_clear(input logic [7:0] c, input int count);
        for (int i = 0; i < count; i++) push_pix(i % 160, i / 160, c);
    endtask

    // Monitor: every fb_write must match the next queued expectation.
    always @(negedge clk) begin : monitor
        logic [23:0] e;
        if (rst === 1'b1 && fb_write === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got (%0d,%0d,%0h) required no write",
                         fb_x_data, fb_y_data, fb_color);
            end else begin
                e = exp_q.pop_front();
                if ({fb_x_data, fb_y_data, fb_color} !== e) begin
                    errors++;
                    $display("FAIL fb_write_data: got (%0d,%0d,%0h) required (%0d,%0d,%0h)",
                             fb_x_data, fb_y_data, fb_color, e[23:16], e[15:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        int n;
        int bad;
        int found;
        logic exp_rdy;

        // Reset state, with cpu_valid high to show cpu_ready is forced low.
        cpu_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_fb_write", fb_write, 0);
        check("rst_clr_busy", clr_busy, 0);
        check("rst_err_oob", err_oob, 0);
        check("rst_fb_xyc", {fb_x_data, fb_y_data, fb_color}, 0);
        @(negedge clk);
        cpu_valid = 1'b0;
        rst = 1'b1;

        // Single CPU write.
        @(negedge clk);
        cpu_valid = 1'b1; cpu_x = 8'd5; cpu_y = 8'd7; cpu_color = 8'hE3;
        push_pix(5, 7, 8'hE3);
        #1 check("cpu_ready_lone", cpu_ready, 1);
        @(negedge clk);
        cpu_valid = 1'b0;
        #1 check("cpu_write_latency", fb_write, 1);

        // Uncontended clear.
        @(negedge clk);
        clr_start = 1'b1; clr_color = 8'h1C;
        push_clear(8'h1C, 19200);
        @(negedge clk);
        clr_start = 1'b0;
        #1 check("clr_cpu_ready_low", cpu_ready, 0);
        n = 0;
        for (int i = 0; i < 40000; i++) begin
            if (clr_busy !== 1'b1) break;
            n++;
            @(negedge clk);
            #1;
        end
        check("clr_busy_cycles", n, 19200);
        check("clr_drain", exp_q.size(), 0);

        // Clear with continuous CPU traffic; CPU also wins the start cycle.
        @(negedge clk);
        clr_start = 1'b1; clr_color = 8'hE0;
        cpu_valid = 1'b1; cpu_x = 8'd9; cpu_y = 8'd9; cpu_color = 8'hAA;
        push_pix(9, 9, 8'hAA);
        for (int k = 0; k < 19200; k++) begin
            push_pix(k % 160, k / 160, 8'hE0);
            if (k < 19199) push_pix(9, 9, 8'hAA);
        end
        #1 check("start_cycle_cpu_ready", cpu_ready, 1);
        @(negedge clk);
        clr_start = 1'b0;
        #1;
        n = 0; bad = 0; exp_rdy = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            if (clr_busy !== 1'b1) break;
            if (cpu_ready !== exp_rdy) bad++;
            exp_rdy = ~exp_rdy;
            n++;
            @(negedge clk);
            #1;
        end
        cpu_valid = 1'b0;
        check("contended_busy_cycles", n, 38399);
        check("ready_toggle_errors", bad, 0);
        @(negedge clk);
        #1 check("contended_drain", exp_q.size(), 0);

        // Clear with an ignored restart, then reset at pixel (40,60).
        @(negedge clk);
        clr_start = 1'b1; clr_color = 8'h3C;
        push_clear(8'h3C, 60 * 160 + 40 + 1);
        @(negedge clk);
        clr_start = 1'b0;
        repeat (100) @(negedge clk);
        clr_start = 1'b1; clr_color = 8'hC3;
        @(negedge clk);
        clr_start = 1'b0;
        #1 check("restart_still_busy", clr_busy, 1);
        found = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            #1;
            if (fb_write === 1'b1 && fb_x_data == 8'd40 && fb_y_data == 8'd60) begin
                found = 1;
                break;
            end
        end
        check("reached_40_60", found, 1);
        rst = 1'b0;
        check("abort_drain", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        #1;
        check("abort_clr_busy", clr_busy, 0);
        check("abort_fb_write", fb_write, 0);
        @(negedge clk);
        rst = 1'b1;

        // Fresh clear after abort restarts at (0,0).
        @(negedge clk);
        clr_start = 1'b1; clr_color = 8'h55;
        push_clear(8'h55, 8);
        @(negedge clk);
        clr_start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        rst = 1'b0;
        check("restart_scan_drain", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;

        // Boundary in-range write, then an out-of-range write.
        @(negedge clk);
        cpu_valid = 1'b1; cpu_x = 8'd159; cpu_y = 8'd119; cpu_color = 8'h11;
        push_pix(159, 119, 8'h11);
        @(negedge clk);
        cpu_x = 8'd160; cpu_y = 8'd3; cpu_color = 8'h77;
`ifndef FB_BOUNDS_CHECK_EN
        push_pix(160, 3, 8'h77);
`endif
        #1 check("oob_cpu_ready", cpu_ready, 1);
        @(negedge clk);
        cpu_valid = 1'b0;
        #1;
`ifdef FB_BOUNDS_CHECK_EN
        check("oob_err_pulse", err_oob, 1);
        check("oob_no_write", fb_write, 0);
`else
        check("oob_err_tied", err_oob, 0);
        check("oob_pass_write", fb_write, 1);
`endif
        @(negedge clk);
        #1;
        check("oob_err_clear", err_oob, 0);
        check("idle_no_write", fb_write, 0);
`ifdef FB_BOUNDS_CHECK_EN
        check("hold_x", fb_x_data, 159);
`else
        check("hold_x", fb_x_data, 160);
`endif
        check("final_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
